// File: rtl/falafel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : falafel_pkg
// Description : Shared widths, memory-op and responder-state types for falafel.
// Revision    : 1.0 - initial release
// ============================================================================
package falafel_pkg;

    localparam int          DATA_W       = 64;
    localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        MEM_RD  = 2'd0,
        MEM_WR  = 2'd1,
        MEM_CAS = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_rsp_state_e;

    // is_cas only qualifies a write; a read ignores it.
    function automatic mem_op_e decode_mem_op(input logic is_write, input logic is_cas);
        if (!is_write) begin
            return MEM_RD;
        end
        return is_cas ? MEM_CAS : MEM_WR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/falafel_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : falafel_mem_responder_if
// Description : LSU <-> memory request/response handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface falafel_mem_responder_if #(
    parameter int DATA_W = falafel_pkg::DATA_W
);
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic              mem_req_is_write;
    logic              mem_req_is_cas;
    logic [DATA_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_rsp_val;
    logic              mem_rsp_rdy;
    logic [DATA_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_val, mem_req_is_write, mem_req_is_cas, mem_req_addr,
               mem_req_data, mem_rsp_rdy,
        input  mem_req_rdy, mem_rsp_val, mem_rsp_data
    );

    modport slave (
        input  mem_req_val, mem_req_is_write, mem_req_is_cas, mem_req_addr,
               mem_req_data, mem_rsp_rdy,
        output mem_req_rdy, mem_rsp_val, mem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/falafel_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : falafel_mem_array
// Description : Single-port word array, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_mem_array #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule
`default_nettype wire

// File: rtl/falafel_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : falafel_mem_responder
// Description : Fixed-latency read/write/CAS responder backed by a word array.
//               Define FALAFEL_MEM_ERR_CHECK_EN for address error checking.
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_mem_responder
    import falafel_pkg::*;
#(
    parameter int DATA_W      = falafel_pkg::DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    falafel_mem_responder_if.slave mem,
    output logic                   err_o
);
    localparam int                c_off      = $clog2(DATA_W / 8);
    localparam int                c_iw       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]        c_cnt_load = 4'(LATENCY - 1);
    localparam logic [DATA_W-1:0] c_idx_mask =
        ((DATA_W'(1) << c_iw) - DATA_W'(1)) << c_off;

    mem_rsp_state_e    r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic              r_res_val, w_res_val_nxt;
    logic [c_iw-1:0]   r_res_idx, w_res_idx_nxt;
    logic [DATA_W-1:0] r_res_value, w_res_value_nxt;
    logic              r_err, w_err_nxt;

    logic              w_req_rdy, w_rsp_val, w_we, w_addr_err, w_cas_ok;
    logic [c_iw-1:0]   w_idx;
    logic [DATA_W-1:0] w_rdata;
    mem_op_e           w_op;

    assign w_idx = mem.mem_req_addr[c_off +: c_iw];
    assign w_op  = decode_mem_op(mem.mem_req_is_write, mem.mem_req_is_cas);

`ifdef FALAFEL_MEM_ERR_CHECK_EN
    assign w_addr_err = |(mem.mem_req_addr & ~c_idx_mask);
`else
    // Out-of-index bits simply wrap onto the array.
    logic w_unused_addr;
    assign w_unused_addr = ^(mem.mem_req_addr & ~c_idx_mask);
    assign w_addr_err    = 1'b0;
`endif

    assign w_cas_ok = r_res_val && (r_res_idx == w_idx) && (w_rdata == r_res_value);

    falafel_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk_i),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (mem.mem_req_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_data  <= '0;
            r_res_val   <= 1'b0;
            r_res_idx   <= '0;
            r_res_value <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_res_val   <= w_res_val_nxt;
            r_res_idx   <= w_res_idx_nxt;
            r_res_value <= w_res_value_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_data_nxt  = r_rsp_data;
        w_res_val_nxt   = r_res_val;
        w_res_idx_nxt   = r_res_idx;
        w_res_value_nxt = r_res_value;
        w_err_nxt       = r_err;
        w_we            = 1'b0;
        w_req_rdy       = 1'b0;
        w_rsp_val       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_rdy = !rst_i;
                if (mem.mem_req_val && !rst_i) begin
                    // The whole operation commits here; later states only time the response.
                    w_err_nxt   = r_err | w_addr_err;
                    w_cnt_nxt   = c_cnt_load;
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                    unique case (w_op)
                        MEM_RD: begin
                            w_rsp_data_nxt = w_addr_err ? DATA_W'(MEM_ERR_DATA) : w_rdata;
                            if (!w_addr_err) begin
                                w_res_val_nxt   = 1'b1;
                                w_res_idx_nxt   = w_idx;
                                w_res_value_nxt = w_rdata;
                            end
                        end
                        MEM_WR: begin
                            w_rsp_data_nxt = '0;
                            w_we           = !w_addr_err;
                            if (!w_addr_err && (r_res_idx == w_idx)) begin
                                w_res_val_nxt = 1'b0;
                            end
                        end
                        default: begin
                            w_we           = w_cas_ok && !w_addr_err;
                            w_rsp_data_nxt = DATA_W'(w_cas_ok && !w_addr_err);
                            w_res_val_nxt  = 1'b0;
                        end
                    endcase
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_rsp_val = 1'b1;
                if (mem.mem_rsp_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem.mem_req_rdy  = w_req_rdy;
    assign mem.mem_rsp_val  = w_rsp_val;
    assign mem.mem_rsp_data = r_rsp_data;
    assign err_o            = r_err;
endmodule
`default_nettype wire

// File: doc/falafel_mem_responder.md
Name: falafel_mem_responder

Overview:
- Memory-side responder for the falafel allocator's memory request/response interface.
- Accepts read, write and CAS requests from the LSU and services them from an internal word array.
- Returns exactly one response per accepted request, after a fixed, parameterised latency.
- Used as the simulation and FPGA backing store for the free-list headers, and as the verification model for CAS contention.

Parameters:
- DATA_W, 64 (falafel_pkg::DATA_W): word and address width.
- DEPTH_WORDS, 1024: number of DATA_W-bit words; must be a power of two.
- LATENCY, 2: cycles from request acceptance to first response-valid cycle; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- mem_req_val_i  in  1  request valid.
- mem_req_rdy_o  out  1  responder ready to accept a request.
- mem_req_is_write_i  in  1  1 = write or CAS, 0 = read.
- mem_req_is_cas_i  in  1  1 = CAS; only meaningful when is_write = 1.
- mem_req_addr_i  in  DATA_W  byte address.
- mem_req_data_i  in  DATA_W  write data / CAS new value.
- mem_rsp_val_o  out  1  response valid.
- mem_rsp_rdy_i  in  1  initiator ready for the response.
- mem_rsp_data_o  out  DATA_W  read data, 0 for a write, CAS flag (1 = success, 0 = fail).
- err_o  out  1  sticky address error (see Optional Feature).

Behaviour:
- Word index: idx = addr[OFF +: IW], where OFF = $clog2(DATA_W/8) and IW = $clog2(DEPTH_WORDS).
- Reset (rst_i high at a clock edge):
  - state = IDLE; mem_req_rdy_o = 0 during reset, 1 on the first cycle after reset.
  - mem_rsp_val_o = 0, mem_rsp_data_o = 0, err_o = 0, reservation invalid.
  - Array contents are not reset.
  - A reset mid-operation drops the pending response; a write/CAS already committed stays committed.
- FSM:
  - IDLE: mem_req_rdy_o = 1. A request is accepted when val & rdy.
  - On acceptance:
    - The operation executes atomically in the acceptance cycle.
    - The response word is latched.
    - cnt is loaded with LATENCY-1.
    - Go to WAIT, or to RESP if LATENCY = 1.
  - WAIT: mem_req_rdy_o = 0; cnt decrements each cycle; at cnt = 0 go to RESP.
  - RESP: mem_rsp_val_o = 1 with data held stable until mem_rsp_rdy_i. On handshake go to IDLE. mem_req_rdy_o = 0.
  - Exactly one outstanding request. A new request is never accepted in the same cycle as a response handshake.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- Operations:
  - Read (is_write = 0; is_cas is ignored):
    - rsp = mem[idx].
    - Sets reservation {valid = 1, idx, value = mem[idx]}, replacing any earlier reservation.
  - Write (is_write = 1, is_cas = 0):
    - mem[idx] = data; rsp = 0.
    - Clears the reservation if its idx matches.
  - CAS (is_write = 1, is_cas = 1):
    - Succeeds iff the reservation is valid, reservation idx == idx, and mem[idx] == reservation value.
    - On success: mem[idx] = data, rsp = 1. On failure: memory unchanged, rsp = 0.
    - The reservation is always cleared afterwards.
- Request inputs are sampled only in the acceptance cycle; they may change freely at other times.
- mem_req_val_i held high while rdy = 0 is legal: the request stays pending, is not lost, and is accepted once rdy rises.

Optional Feature:
- Macro: FALAFEL_MEM_ERR_CHECK_EN.
- Defined:
  - An address with nonzero low OFF bits, or with any bit above OFF+IW-1 set, is an error.
  - On error: the request is still accepted and responded to with the normal latency. Read rsp = 'hDEAD_BEEF zero-extended; write/CAS perform no memory update and return rsp = 0.
  - err_o sets and stays set until reset.
- Not defined: address bits outside the index are ignored (modulo wrap); err_o is tied to 0.

Decomposition:
- falafel_pkg gains:
  - mem_op_e {MEM_RD, MEM_WR, MEM_CAS}, decoded from is_write/is_cas;
  - mem_rsp_state_e {IDLE, WAIT, RESP};
  - constant MEM_ERR_DATA.
- One sub-module, falafel_mem_array: single-port synchronous-write / asynchronous-read word array with DEPTH_WORDS entries.
- The FSM, latency counter, reservation register and error logic live in falafel_mem_responder.

Test Plan:
- Read/write/latency:
  - Stimulus: LATENCY = 2; write 0x40 <- 0x1234, then read 0x40.
  - Required: each rsp_val rises exactly 2 cycles after acceptance; write rsp = 0; read rsp = 0x1234.
- CAS success and reuse:
  - Stimulus: read 0x80 (returns 0x10); CAS 0x80 <- 0x20; then a second CAS 0x80 <- 0x30.
  - Required: first CAS rsp = 1 and mem = 0x20; second CAS rsp = 0 (reservation cleared) and mem stays 0x20.
- Interleaved write kills the reservation:
  - Stimulus: read 0x80; plain write 0x80 <- 0x55; CAS 0x80 <- 0x99.
  - Required: CAS rsp = 0 and mem = 0x55.
- Response backpressure:
  - Stimulus: hold mem_rsp_rdy_i = 0 for 5 cycles while mem_req_val_i is held with a second request.
  - Required: rsp_val and data stable throughout; req_rdy stays 0; the second request is accepted the cycle after the response handshake.
- Reset mid-operation:
  - Stimulus: assert rst_i in WAIT after a write of 0x77 to 0x100.
  - Required: no response is emitted; after reset req_rdy = 1; a read of 0x100 returns 0x77.
- Error check (with FALAFEL_MEM_ERR_CHECK_EN):
  - Stimulus: read addr 0x3, then write addr 0x3 <- 0x1.
  - Required: read rsp = 0xDEADBEEF; err_o = 1 and sticky; the write does not change memory.
  - Without the macro: the same read returns mem[0] and err_o = 0.
